arm_ctrl_pipe: RTL and testbench
================================

# arm_ctrl_pipe

Parametrised control path for the ARM pipeline: decodes the instruction in ID into a control bundle, then carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It sits between the IF/ID instruction register and the datapath stage muxes. It adds three behaviours to the plain combinational decoder:
- bubble insertion on stall and flush;
- condition-code evaluation in EX, which annuls state-changing enables;
- a saturating retired-instruction counter.

## Interface
Parameters:
- COND_EVAL, 1: 1 evaluates cond field [31:28] in EX; 0 treats every instruction as AL.
- FLUSH_EXMEM, 0: 1 makes `flush` also bubble EX/MEM (branch resolved in MEM); 0 bubbles ID/EX only.
- CNT_W, 16: width of `instr_count`.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  32  instruction currently in ID.
- id_valid  in  1  `instr_in` holds a real instruction.
- stall  in  1  hazard unit: load a bubble into ID/EX this edge.
- flush  in  1  branch taken: discard younger work.
- flags  in  4  NZCV from the status register, sampled while the instruction is in EX.
- ex_alu_op  out  4  ALU opcode.
- ex_am  out  1  shifter-operand mode (instr[25]).
- ex_s_enable  out  1  update flags; 0 on condition fail.
- ex_b, ex_bl  out  1 each  branch and branch-with-link; 0 on condition fail.
- ex_branch_taken  out  1  equals ex_b | ex_bl (already condition-qualified).
- mem_load, mem_size_word, mem_rw, mem_enable  out  1 each  memory controls.
- wb_rf_enable  out  1  register-file write.
- instr_count  out  CNT_W  retired-instruction count, saturating.

## Operation
Decode is combinational on `instr_in`. A bubble is all enables 0, alu_op 4'b0000, valid 0.

Data processing (class 000 with !(instr[7]&instr[4]), or class 001):
- alu_op map: AND→0110, EOR→1000, SUB→0010, RSB→0100, ADD→0000, ADC→0001, SBC→0011, RSC→0101, ORR→0111, MOV→1010, BIC→1100, MVN→1011.
- TST/TEQ/CMP/CMN (1000–1011) map to 0110/1000/0010/0000 with rf_enable=0 and s_enable forced to 1.
- All other opcodes: rf_enable=1, s_enable=instr[20].

Load/store (class 010, or class 011 with instr[4]=0):
- mem_enable=1, size_word=~instr[22], alu_op=instr[23] ? 0000 : 0010.
- L (instr[20]=1): load=1, rw=0, rf_enable=1.
- Store (instr[20]=0): rw=1, rf_enable=0.

Branch (class 101):
- instr[24]=0: B.
- instr[24]=1: BL, with rf_enable=1 (link write).

Instruction 32'h0 and all other encodings decode to a bubble.

ID/EX register:
- Loads a bubble if reset | stall | flush | !id_valid; otherwise loads the decoded bundle plus the cond field.

Condition evaluation in EX:
- cond_pass follows the full ARM table for EQ..AL (0000–1110); 1111 fails.
- COND_EVAL=0 forces cond_pass=1.
- On fail, s_enable, b, bl, load, rw, mem_enable, rf_enable and valid are cleared before they reach the ex_* outputs and EX/MEM.

EX/MEM register:
- Always advances.
- Loads a bubble on reset, or on flush when FLUSH_EXMEM=1.

MEM/WB register:
- Always advances; cleared on reset.
- Carries rf_enable and valid.

instr_count:
- Increments on every edge where the MEM/WB valid bit is 1.
- Holds at all-ones.
- Cleared by reset.

## Timing
- Reset: every output reads 0 on the edge after reset is asserted, including instr_count and ex_alu_op=0000.
- Latency for an instruction in ID in cycle t (id_valid=1, stall=0, flush=0):
  - ex_* valid in cycle t+1;
  - mem_* valid in t+2;
  - wb_rf_enable valid in t+3;
  - instr_count reflects it from t+4.
- stall and flush are sampled on the same edge as `instr_in`; the upstream stages hold or clear themselves.
- Simultaneous stall and flush: one bubble, same result as either alone.
- Reset mid-pipeline: all in-flight bundles are discarded; no count increments on the reset edge.
- ex_branch_taken is purely combinational from ID/EX and `flags`; `flags` must be stable before the edge.

## Test plan
- Reset: assert reset for 2 cycles with a valid ADD in ID → every output 0 and instr_count=0 throughout.
- ADDS r1,r2,r3 (32'hE0921003) with id_valid=1 → t+1: ex_alu_op=0000, ex_s_enable=1; t+3: wb_rf_enable=1; t+4: instr_count=1.
- LDRB r0,[r1,#-4] (32'hE5510004) → t+1: ex_alu_op=0010; t+2: mem_load=1, mem_size_word=0, mem_enable=1, mem_rw=0; t+3: wb_rf_enable=1.
- BEQ (32'h0A000004) with flags=4'b0000 → ex_b=0, ex_branch_taken=0, instr_count unchanged; same instruction with flags=4'b0100 → ex_branch_taken=1 and count +1.
- STR followed by ADD with stall=1 on the ADD cycle → ID/EX bubble (ex_alu_op=0000, all enables 0); mem_rw=1 for the STR is still seen at t+2 and wb_rf_enable=0 for the STR.
- Saturation: CNT_W=4 with 20 back-to-back MOVs → instr_count stops at 4'hF. FLUSH_EXMEM=1 with flush asserted while a STR is in EX → mem_enable=0 on the next cycle.

Source files
------------

// File: rtl/arm_ctrl_pipe.sv
// ARM pipeline control path: decodes the instruction in ID, then carries the control bundle
// through ID/EX, EX/MEM and MEM/WB with bubbles, EX condition annulment and a retired counter.
module arm_ctrl_pipe #(
  parameter bit COND_EVAL   = 1'b1,
  parameter bit FLUSH_EXMEM = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic             id_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       flags,
  output logic [3:0]       ex_alu_op,
  output logic             ex_am,
  output logic             ex_s_enable,
  output logic             ex_b,
  output logic             ex_bl,
  output logic             ex_branch_taken,
  output logic             mem_load,
  output logic             mem_size_word,
  output logic             mem_rw,
  output logic             mem_enable,
  output logic             wb_rf_enable,
  output logic [CNT_W-1:0] instr_count
);

  typedef struct packed {
    logic [3:0] alu_op;
    logic       am;
    logic       s_enable;
    logic       b;
    logic       bl;
    logic       load;
    logic       size_word;
    logic       rw;
    logic       mem_enable;
    logic       rf_enable;
    logic       valid;
  } ctrl_t;

  typedef struct packed {
    logic load;
    logic size_word;
    logic rw;
    logic mem_enable;
    logic rf_enable;
    logic valid;
  } mem_ctrl_t;

  localparam ctrl_t     CTRL_BUBBLE = ctrl_t'(14'h0000);
  localparam mem_ctrl_t MEM_BUBBLE  = mem_ctrl_t'(6'h00);

  function automatic logic [3:0] dp_alu_op(input logic [3:0] opcode);
    logic [3:0] op_v;
    case (opcode)
      4'b0000: op_v = 4'b0110;
      4'b0001: op_v = 4'b1000;
      4'b0010: op_v = 4'b0010;
      4'b0011: op_v = 4'b0100;
      4'b0100: op_v = 4'b0000;
      4'b0101: op_v = 4'b0001;
      4'b0110: op_v = 4'b0011;
      4'b0111: op_v = 4'b0101;
      4'b1000: op_v = 4'b0110;
      4'b1001: op_v = 4'b1000;
      4'b1010: op_v = 4'b0010;
      4'b1011: op_v = 4'b0000;
      4'b1100: op_v = 4'b0111;
      4'b1101: op_v = 4'b1010;
      4'b1110: op_v = 4'b1100;
      4'b1111: op_v = 4'b1011;
      default: op_v = 4'b0000;
    endcase
    return op_v;
  endfunction

  // nzcv = {N, Z, C, V}; the reserved 1111 condition never passes
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic pass_v;
    case (cond)
      4'b0000: pass_v = nzcv[2];
      4'b0001: pass_v = !nzcv[2];
      4'b0010: pass_v = nzcv[1];
      4'b0011: pass_v = !nzcv[1];
      4'b0100: pass_v = nzcv[3];
      4'b0101: pass_v = !nzcv[3];
      4'b0110: pass_v = nzcv[0];
      4'b0111: pass_v = !nzcv[0];
      4'b1000: pass_v = nzcv[1] && !nzcv[2];
      4'b1001: pass_v = !nzcv[1] || nzcv[2];
      4'b1010: pass_v = (nzcv[3] == nzcv[0]);
      4'b1011: pass_v = (nzcv[3] != nzcv[0]);
      4'b1100: pass_v = !nzcv[2] && (nzcv[3] == nzcv[0]);
      4'b1101: pass_v = nzcv[2] || (nzcv[3] != nzcv[0]);
      4'b1110: pass_v = 1'b1;
      default: pass_v = 1'b0;
    endcase
    return pass_v;
  endfunction

  logic [2:0]  instr_cls_s;
  logic [3:0]  opcode_s;
  ctrl_t       dec_s;
  ctrl_t       idex_r;
  logic [3:0]  idex_cond_r;
  logic        cond_pass_s;
  ctrl_t       ex_s;
  mem_ctrl_t   exmem_r;
  logic        memwb_rf_r;
  logic        memwb_valid_r;
  logic [CNT_W-1:0] count_r;

  assign instr_cls_s = instr_in[27:25];
  assign opcode_s    = instr_in[24:21];

  // Combinational decode of the ID instruction into a control bundle
  always_comb begin
    dec_s = CTRL_BUBBLE;
    if (instr_in == 32'h0000_0000) begin
      dec_s = CTRL_BUBBLE;
    end else if (((instr_cls_s == 3'b000) && !(instr_in[7] && instr_in[4])) ||
                 (instr_cls_s == 3'b001)) begin
      dec_s.valid  = 1'b1;
      dec_s.am     = instr_in[25];
      dec_s.alu_op = dp_alu_op(opcode_s);
      // TST/TEQ/CMP/CMN only set flags
      if (opcode_s[3:2] == 2'b10) begin
        dec_s.rf_enable = 1'b0;
        dec_s.s_enable  = 1'b1;
      end else begin
        dec_s.rf_enable = 1'b1;
        dec_s.s_enable  = instr_in[20];
      end
    end else if ((instr_cls_s == 3'b010) ||
                 ((instr_cls_s == 3'b011) && !instr_in[4])) begin
      dec_s.valid      = 1'b1;
      dec_s.am         = instr_in[25];
      dec_s.mem_enable = 1'b1;
      dec_s.size_word  = !instr_in[22];
      dec_s.alu_op     = instr_in[23] ? 4'b0000 : 4'b0010;
      dec_s.load       = instr_in[20];
      dec_s.rw         = !instr_in[20];
      dec_s.rf_enable  = instr_in[20];
    end else if (instr_cls_s == 3'b101) begin
      dec_s.valid     = 1'b1;
      dec_s.am        = instr_in[25];
      dec_s.b         = !instr_in[24];
      dec_s.bl        = instr_in[24];
      dec_s.rf_enable = instr_in[24];
    end else begin
      dec_s = CTRL_BUBBLE;
    end
  end

  // ID/EX control register with bubble insertion
  always_ff @(posedge clk) begin
    if (reset || stall || flush || !id_valid) begin
      idex_r      <= CTRL_BUBBLE;
      idex_cond_r <= 4'b0000;
    end else begin
      idex_r      <= dec_s;
      idex_cond_r <= instr_in[31:28];
    end
  end

  assign cond_pass_s = COND_EVAL ? cond_check(idex_cond_r, flags) : 1'b1;

  // EX-stage bundle with state-changing enables annulled on condition fail
  always_comb begin
    ex_s = idex_r;
    if (!cond_pass_s) begin
      ex_s.s_enable   = 1'b0;
      ex_s.b          = 1'b0;
      ex_s.bl         = 1'b0;
      ex_s.load       = 1'b0;
      ex_s.rw         = 1'b0;
      ex_s.mem_enable = 1'b0;
      ex_s.rf_enable  = 1'b0;
      ex_s.valid      = 1'b0;
    end else begin
      ex_s = idex_r;
    end
  end

  // EX/MEM control register; optionally squashed by a late branch
  always_ff @(posedge clk) begin
    if (reset || (FLUSH_EXMEM && flush)) begin
      exmem_r <= MEM_BUBBLE;
    end else begin
      exmem_r <= '{load: ex_s.load, size_word: ex_s.size_word, rw: ex_s.rw,
                   mem_enable: ex_s.mem_enable, rf_enable: ex_s.rf_enable,
                   valid: ex_s.valid};
    end
  end

  // MEM/WB control register
  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_rf_r    <= 1'b0;
      memwb_valid_r <= 1'b0;
    end else begin
      memwb_rf_r    <= exmem_r.rf_enable;
      memwb_valid_r <= exmem_r.valid;
    end
  end

  // Saturating retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (memwb_valid_r && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign ex_alu_op       = ex_s.alu_op;
  assign ex_am           = ex_s.am;
  assign ex_s_enable     = ex_s.s_enable;
  assign ex_b            = ex_s.b;
  assign ex_bl           = ex_s.bl;
  assign ex_branch_taken = ex_s.b | ex_s.bl;
  assign mem_load        = exmem_r.load;
  assign mem_size_word   = exmem_r.size_word;
  assign mem_rw          = exmem_r.rw;
  assign mem_enable      = exmem_r.mem_enable;
  assign wb_rf_enable    = memwb_rf_r;
  assign instr_count     = count_r;

endmodule

// File: tb/tb_arm_ctrl_pipe.sv
// Bench for arm_ctrl_pipe: decode table, directed latency/stall/flush/saturation sequences and
// randomized traffic against a stage-record reference model, on two parameterisations.
module tb_arm_ctrl_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] instr_in;
  logic        id_valid;
  logic        stall;
  logic        flush;
  logic [3:0]  flags;

  logic [3:0]  ex_alu_op0, ex_alu_op1;
  logic        ex_am0, ex_s0, ex_b0, ex_bl0, ex_bt0, mem_ld0, mem_sw0, mem_rw0, mem_en0, wb_rf0;
  logic        ex_am1, ex_s1, ex_b1, ex_bl1, ex_bt1, mem_ld1, mem_sw1, mem_rw1, mem_en1, wb_rf1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  arm_ctrl_pipe #(.COND_EVAL(1'b1), .FLUSH_EXMEM(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .instr_in(instr_in), .id_valid(id_valid), .stall(stall),
    .flush(flush), .flags(flags), .ex_alu_op(ex_alu_op0), .ex_am(ex_am0), .ex_s_enable(ex_s0),
    .ex_b(ex_b0), .ex_bl(ex_bl0), .ex_branch_taken(ex_bt0), .mem_load(mem_ld0),
    .mem_size_word(mem_sw0), .mem_rw(mem_rw0), .mem_enable(mem_en0), .wb_rf_enable(wb_rf0),
    .instr_count(cnt0));

  arm_ctrl_pipe #(.COND_EVAL(1'b1), .FLUSH_EXMEM(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .instr_in(instr_in), .id_valid(id_valid), .stall(stall),
    .flush(flush), .flags(flags), .ex_alu_op(ex_alu_op1), .ex_am(ex_am1), .ex_s_enable(ex_s1),
    .ex_b(ex_b1), .ex_bl(ex_bl1), .ex_branch_taken(ex_bt1), .mem_load(mem_ld1),
    .mem_size_word(mem_sw1), .mem_rw(mem_rw1), .mem_enable(mem_en1), .wb_rf_enable(wb_rf1),
    .instr_count(cnt1));

  logic [8:0]  ex_vec  [2];
  logic [3:0]  mem_vec [2];
  logic        wb_vec  [2];
  logic [15:0] cnt_vec [2];
  assign ex_vec[0]  = {ex_alu_op0, ex_am0, ex_s0, ex_b0, ex_bl0, ex_bt0};
  assign ex_vec[1]  = {ex_alu_op1, ex_am1, ex_s1, ex_b1, ex_bl1, ex_bt1};
  assign mem_vec[0] = {mem_ld0, mem_sw0, mem_rw0, mem_en0};
  assign mem_vec[1] = {mem_ld1, mem_sw1, mem_rw1, mem_en1};
  assign wb_vec[0]  = wb_rf0;
  assign wb_vec[1]  = wb_rf1;
  assign cnt_vec[0] = cnt0;
  assign cnt_vec[1] = {12'h000, cnt1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] alu;
    logic am, s, b, bl, ld, sw, rw, me, rf, v;
    logic [3:0] cond;
  } rec_t;

  logic [3:0] alu_tab [16] = '{4'h6, 4'h8, 4'h2, 4'h4, 4'h0, 4'h1, 4'h3, 4'h5,
                               4'h6, 4'h8, 4'h2, 4'h0, 4'h7, 4'hA, 4'hC, 4'hB};
  rec_t m_ex [2];
  rec_t m_mem [2];
  rec_t m_wb [2];
  int   m_cnt [2];
  int   cnt_max [2] = '{65535, 15};
  logic m_init = 1'b0;

  function automatic rec_t ref_decode(input logic [31:0] ins);
    rec_t r;
    int cls;
    int op;
    r = '0;
    cls = int'(ins[27:25]);
    op = int'(ins[24:21]);
    r.cond = ins[31:28];
    if (ins == 32'h0) return r;
    if ((cls == 0 && !(ins[7] && ins[4])) || cls == 1) begin
      r.v = 1'b1; r.am = ins[25]; r.alu = alu_tab[op];
      r.s  = (op >= 8 && op <= 11) ? 1'b1 : ins[20];
      r.rf = (op >= 8 && op <= 11) ? 1'b0 : 1'b1;
    end else if (cls == 2 || (cls == 3 && !ins[4])) begin
      r.v = 1'b1; r.am = ins[25]; r.me = 1'b1; r.sw = !ins[22];
      r.alu = ins[23] ? 4'h0 : 4'h2;
      r.ld = ins[20]; r.rw = !ins[20]; r.rf = ins[20];
    end else if (cls == 5) begin
      r.v = 1'b1; r.am = ins[25]; r.b = !ins[24]; r.bl = ins[24]; r.rf = ins[24];
    end
    return r;
  endfunction

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cf;         4'h3: return !cf;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cf && !z;   4'h9: return !cf || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic rec_t qualify(input rec_t r, input logic [3:0] f);
    rec_t q;
    q = r;
    if (!ref_cond(r.cond, f)) begin
      q.s = 1'b0; q.b = 1'b0; q.bl = 1'b0; q.ld = 1'b0; q.rw = 1'b0;
      q.me = 1'b0; q.rf = 1'b0; q.v = 1'b0;
    end
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    rec_t q;
    for (int k = 0; k < 2; k++) begin
      q = qualify(m_ex[k], flags);
      chk($sformatf("model ex%0d", k), {23'h0, ex_vec[k]},
          {23'h0, q.alu, q.am, q.s, q.b, q.bl, q.b | q.bl});
      chk($sformatf("model mem%0d", k), {28'h0, mem_vec[k]},
          {28'h0, m_mem[k].ld, m_mem[k].sw, m_mem[k].rw, m_mem[k].me});
      chk($sformatf("model wb%0d", k), {31'h0, wb_vec[k]}, {31'h0, m_wb[k].rf});
      chk($sformatf("model cnt%0d", k), {16'h0, cnt_vec[k]}, m_cnt[k]);
    end
  endtask

  task automatic apply(input logic r, input logic [31:0] ins, input logic v, input logic st,
                       input logic fl, input logic [3:0] fg);
    reset = r; instr_in = ins; id_valid = v; stall = st; flush = fl; flags = fg;
    #2;
    if (m_init) check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) m_cnt[k] = 0;
      else if (m_wb[k].v && m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
      m_wb[k]  = reset ? rec_t'(0) : m_mem[k];
      m_mem[k] = (reset || (k == 1 && flush)) ? rec_t'(0) : qualify(m_ex[k], flags);
      m_ex[k]  = (reset || stall || flush || !id_valid) ? rec_t'(0) : ref_decode(instr_in);
    end
    if (reset) m_init = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick();
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  fl;
    logic [8:0]  exp_ex;   // {alu_op, am, s_enable, b, bl, branch_taken}
  } vec_t;

  vec_t tab [18];

  localparam logic [31:0] ADDS = 32'hE0921003;
  localparam logic [31:0] LDRB = 32'hE5510004;
  localparam logic [31:0] BEQ  = 32'h0A000004;
  localparam logic [31:0] STR  = 32'hE5810000;
  localparam logic [31:0] ADD  = 32'hE0821003;
  localparam logic [31:0] MOV  = 32'hE1A00001;

  initial begin
    tab[0]  = '{ADDS,         4'h0, {4'h0, 5'b01000}};
    tab[1]  = '{LDRB,         4'h0, {4'h2, 5'b00000}};
    tab[2]  = '{BEQ,          4'h4, {4'h0, 5'b10101}};
    tab[3]  = '{BEQ,          4'h0, {4'h0, 5'b10000}};
    tab[4]  = '{32'hE3510005, 4'h0, {4'h2, 5'b11000}};
    tab[5]  = '{MOV,          4'h0, {4'hA, 5'b00000}};
    tab[6]  = '{32'hEB000010, 4'h0, {4'h0, 5'b10011}};
    tab[7]  = '{32'h00000000, 4'h4, {4'h0, 5'b00000}};
    tab[8]  = '{32'h31F00000, 4'h2, {4'hB, 5'b00000}};
    tab[9]  = '{32'h31F00000, 4'h0, {4'hB, 5'b01000}};
    tab[10] = '{32'hE1000001, 4'h0, {4'h6, 5'b01000}};
    tab[11] = '{32'hE0010291, 4'h0, {4'h0, 5'b00000}};
    tab[12] = '{32'hF1B00001, 4'hF, {4'hA, 5'b00000}};
    tab[13] = '{STR,          4'h0, {4'h0, 5'b00000}};
    tab[14] = '{32'hE1C00001, 4'h0, {4'hC, 5'b00000}};
    tab[15] = '{32'hE6000010, 4'h0, {4'h0, 5'b00000}};
    tab[16] = '{32'hA0700000, 4'h8, {4'h4, 5'b00000}};
    tab[17] = '{32'hA0700000, 4'h9, {4'h4, 5'b01000}};

    // Reset for two cycles with a valid ADD sitting in ID
    apply(1'b1, ADD, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    apply(1'b1, ADD, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    chk("reset outputs0", {ex_vec[0], mem_vec[0], wb_vec[0], cnt_vec[0]}, 32'h0);
    chk("reset outputs1", {ex_vec[1], mem_vec[1], wb_vec[1], cnt_vec[1]}, 32'h0);

    // ADDS latency through to the counter
    apply(1'b0, ADDS, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("adds ex alu_op", {28'h0, ex_alu_op0}, 32'h0);
    chk("adds ex s", {31'h0, ex_s0}, 32'h1);
    tick(); idle(1);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("adds wb rf", {31'h0, wb_rf0}, 32'h1);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("adds count", {16'h0, cnt0}, 32'd1);
    tick();

    // LDRB through MEM and WB
    apply(1'b0, LDRB, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("ldrb ex alu_op", {28'h0, ex_alu_op0}, 32'h2);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("ldrb mem", {28'h0, mem_vec[0]}, 32'h9);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("ldrb wb rf", {31'h0, wb_rf0}, 32'h1);
    tick(); idle(2);

    // BEQ not taken (Z=0), then taken (Z=1)
    apply(1'b0, BEQ, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("beq nt b/taken", {30'h0, ex_b0, ex_bt0}, 32'h0);
    tick(); idle(3);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("beq nt count", {16'h0, cnt0}, 32'd2);
    tick();
    apply(1'b0, BEQ, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h4);
    chk("beq t taken", {31'h0, ex_bt0}, 32'h1);
    tick(); idle(3);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("beq t count", {16'h0, cnt0}, 32'd3);
    tick();

    // STR followed by a stalled ADD
    apply(1'b0, STR, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    apply(1'b0, ADD, 1'b1, 1'b1, 1'b0, 4'h0); tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("stall bubble ex", {23'h0, ex_vec[0]}, 32'h0);
    chk("str mem rw", {31'h0, mem_rw0}, 32'h1);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("str wb rf", {31'h0, wb_rf0}, 32'h0);
    tick();

    // 20 back-to-back MOVs saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, MOV, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    end
    idle(4);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("sat count", {28'h0, cnt1}, 32'hF);
    tick();

    // Flush while STR is in EX: only the FLUSH_EXMEM=1 instance drops it
    apply(1'b0, STR, 1'b1, 1'b0, 1'b0, 4'h0); tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0); tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("flush exmem en1", {31'h0, mem_en1}, 32'h0);
    chk("flush exmem en0", {31'h0, mem_en0}, 32'h1);
    tick();

    // Decode / condition table
    for (int i = 0; i < 18; i++) begin
      apply(1'b0, tab[i].instr, 1'b1, 1'b0, 1'b0, 4'h0); tick();
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, tab[i].fl);
      chk($sformatf("table ex[%0d]", i), {23'h0, ex_vec[0]}, {23'h0, tab[i].exp_ex});
      tick();
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      logic [2:0]  cls;
      ins = $urandom;
      case ($urandom_range(0, 6))
        0: cls = 3'b000;
        1: cls = 3'b001;
        2: cls = 3'b010;
        3: cls = 3'b011;
        4: cls = 3'b101;
        5: cls = 3'b101;
        default: cls = ins[27:25];
      endcase
      ins[27:25] = cls;
      if ($urandom_range(0, 19) == 0) ins = 32'h0;
      if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
      apply($urandom_range(0, 59) == 0, ins, $urandom_range(0, 7) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 4'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
